// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus field widths and the target FSM state encoding.
// Intended to be imported by both the I2C target and the single-byte master.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  // Receive FSM states
  localparam logic [2:0] ST_IDLE = 3'd0;  // bus free, waiting for START
  localparam logic [2:0] ST_ADDR = 3'd1;  // shifting address + R/W
  localparam logic [2:0] ST_ACK  = 3'd2;  // holding SDA low through the 9th clock
  localparam logic [2:0] ST_DATA = 3'd3;  // shifting a data byte
  localparam logic [2:0] ST_SKIP = 3'd4;  // not addressed, ignore until STOP/START

endpackage

// File: rtl/i2c_line_sync.sv
// Bus-pin front end for the I2C target: 2-flop synchronizers on SCL/SDA,
// a level/history flop pair per line, and SCL edge plus START/STOP detection.
//
// Optional build macro: I2C_TGT_GLITCH_FILTER_EN
//   defined   - each synchronized line must hold 3 consecutive equal samples
//               before its level changes (spikes up to 2 clk are dropped);
//               pin-to-event latency is 5 clk.
//   undefined - no filter; pin-to-event latency is 3 clk.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   scl_in, sda_in     raw asynchronous bus pin levels
//   scl_rise/scl_fall  one-clk pulses on synchronized SCL edges
//   sda_bit            synchronized SDA level, valid to sample on scl_rise
//   start_det          SDA fell while SCL high
//   stop_det           SDA rose while SCL high
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_bit,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_lvl_d;
  logic       sda_lvl_d;
  logic       scl_lvl_q;
  logic       sda_lvl_q;

  // Synchronizers and level history. Reset to the idle (released) bus level
  // so leaving reset never fabricates a START or STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_lvl_q  <= 1'b1;
      sda_lvl_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_lvl_q  <= scl_lvl_d;
      sda_lvl_q  <= sda_lvl_d;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  // Two previous synchronized samples; together with the current one they
  // form the 3-sample stability window.
  logic [1:0] scl_win_q;
  logic [1:0] sda_win_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_win_q <= 2'b11;
      sda_win_q <= 2'b11;
    end else begin
      scl_win_q <= {scl_win_q[0], scl_sync_q[1]};
      sda_win_q <= {sda_win_q[0], sda_sync_q[1]};
    end
  end

  always_comb begin
    scl_lvl_d = scl_lvl_q;
    sda_lvl_d = sda_lvl_q;
    if ((scl_sync_q[1] == scl_win_q[0]) && (scl_win_q[0] == scl_win_q[1]))
      scl_lvl_d = scl_sync_q[1];
    if ((sda_sync_q[1] == sda_win_q[0]) && (sda_win_q[0] == sda_win_q[1]))
      sda_lvl_d = sda_sync_q[1];
  end
`else
  always_comb begin
    scl_lvl_d = scl_sync_q[1];
    sda_lvl_d = sda_sync_q[1];
  end
`endif

  // SCL must be high both before and after the SDA transition for START/STOP.
  always_comb begin
    scl_rise  = scl_lvl_d & ~scl_lvl_q;
    scl_fall  = ~scl_lvl_d & scl_lvl_q;
    sda_bit   = sda_lvl_d;
    start_det = scl_lvl_d & scl_lvl_q & sda_lvl_q & ~sda_lvl_d;
    stop_det  = scl_lvl_d & scl_lvl_q & ~sda_lvl_q & sda_lvl_d;
  end

endmodule

// File: rtl/i2c_target_rx.sv
// Byte-receiving I2C target. Oversamples SCL/SDA (clk >= 8x SCL, or >= 12x
// with I2C_TGT_GLITCH_FILTER_EN defined), matches a 7-bit address, ACKs by
// pulling SDA low and strobes every received data byte.
//
// Optional build macro: I2C_TGT_GLITCH_FILTER_EN (see i2c_line_sync).
//
// Parameters:
//   OWN_ADDR   7-bit address this target answers to
//   IGNORE_RW  1: accept either R/W value; 0: R/W=1 is NACKed like a mismatch
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   scl_in       raw SCL pin
//   sda_in       raw SDA pin
//   sda_pull     1 = drive SDA low (open-drain enable)
//   rx_data      last received data byte (first bus bit is the MSB)
//   rx_valid     one-clk pulse when rx_data updates
//   rw_bit       R/W bit of the last matched address phase
//   addr_hit     one-clk pulse when the address matches and ACK is driven
//   busy         high from START to STOP
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR  = 7'h3C,
  parameter logic                  IGNORE_RW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_pull,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rw_bit,
  output logic                  addr_hit,
  output logic                  busy
);

  logic scl_rise;
  logic scl_fall;
  logic sda_bit;
  logic start_det;
  logic stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_bit   (sda_bit),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  logic [2:0]            state_q,    state_d;
  logic [2:0]            bit_cnt_q,  bit_cnt_d;
  logic                  done_q,     done_d;     // 8th bit shifted, waiting for its SCL fall
  logic                  sda_pull_q, sda_pull_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rw_bit_q,   rw_bit_d;
  logic                  addr_hit_q, addr_hit_d;
  logic                  busy_q,     busy_d;
  logic [I2C_BYTE_W-1:0] rx_data_q,  rx_data_d;
  logic [I2C_BYTE_W-1:0] shift_q,    shift_d;
  logic [I2C_BYTE_W-1:0] shift_in;
  logic                  addr_ok;

  assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda_bit};
  assign addr_ok  = (shift_q[I2C_BYTE_W-1:1] == OWN_ADDR) && (IGNORE_RW || !shift_q[0]);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    done_d     = done_q;
    sda_pull_d = sda_pull_q;
    rx_valid_d = 1'b0;
    rw_bit_d   = rw_bit_q;
    addr_hit_d = 1'b0;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    shift_d    = shift_q;

    // Bus conditions override bit handling; any partial byte is dropped.
    if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = 3'(I2C_BYTE_W - 1);
      done_d     = 1'b0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b1;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise && !done_q) begin
            shift_d = shift_in;
            if (bit_cnt_q == 3'd0) begin
              done_d = 1'b1;
              if (state_q == ST_DATA) begin
                rx_data_d  = shift_in;
                rx_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && done_q) begin
            // SCL is low now, so SDA may be claimed for the ACK bit.
            done_d = 1'b0;
            if (state_q == ST_DATA) begin
              sda_pull_d = 1'b1;
              state_d    = ST_ACK;
            end else if (addr_ok) begin
              sda_pull_d = 1'b1;
              addr_hit_d = 1'b1;
              rw_bit_d   = shift_q[0];
              state_d    = ST_ACK;
            end else begin
              state_d = ST_SKIP;
            end
          end
        end
        ST_ACK: begin
          // First fall after entering ACK ends the 9th clock.
          if (scl_fall) begin
            sda_pull_d = 1'b0;
            state_d    = ST_DATA;
            bit_cnt_d  = 3'(I2C_BYTE_W - 1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      done_q     <= 1'b0;
      sda_pull_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rw_bit_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
      sda_pull_q <= sda_pull_d;
      rx_valid_q <= rx_valid_d;
      rw_bit_q   <= rw_bit_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Shift register is pure data; every byte starts from a START or ACK.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sda_pull = sda_pull_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw_bit   = rw_bit_q;
  assign addr_hit = addr_hit_q;
  assign busy     = busy_q;

endmodule
